// File: rtl/reg_spi_engine.sv
// reg_spi_engine: serial back-end for the acquisition controller.
//
// One command is accepted at a time over a level load/done handshake. Depending on the mode,
// a command shifts a REG_BITS word into the external enable/chip-select shift-register chain
// and latches it, then optionally performs an 8-bit or 9-bit write or a READ_BITS read on the
// ADC SPI bus. Every pin output comes straight from a flop.
//
// Optional feature macro: REGSPI_READ_EN. When it is defined, modes 3 and 6 perform reads.
// When it is undefined, mode 3 acts as REG, mode 6 is a no-op, read_data/read_valid are
// tied low and spi_miso is ignored.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   regspi_load     command request (level)
//   regspi_mode     0 REG, 1 REG_SPI8, 2 REG_SPI9, 3 REG_READ, 4 SPI8, 5 SPI9, 6 READ, else no-op
//   reg_word        shift-register word, sent MSB first
//   spi_word8       SPI write byte, sent MSB first
//   reg_en_n        chain output enable request
//   regspi_done     command complete (level)
//   reg_sclk/sdo    shift-register clock and data
//   reg_latch       shift-register storage strobe
//   reg_oe_n        registered copy of reg_en_n
//   spi_sclk/mosi   ADC SPI clock and data out
//   spi_miso        ADC SPI data in
//   read_data       last captured read word
//   read_valid      one-cycle pulse when read_data updates
`timescale 1ns/1ps
module reg_spi_engine #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned REG_BITS  = 24,
  parameter int unsigned READ_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 regspi_load,
  input  logic [3:0]           regspi_mode,
  input  logic [REG_BITS-1:0]  reg_word,
  input  logic [7:0]           spi_word8,
  input  logic                 reg_en_n,
  output logic                 regspi_done,
  output logic                 reg_sclk,
  output logic                 reg_sdo,
  output logic                 reg_latch,
  output logic                 reg_oe_n,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic [READ_BITS-1:0] read_data,
  output logic                 read_valid
);

  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MaxA    = (REG_BITS > READ_BITS) ? REG_BITS : READ_BITS;
  localparam int unsigned MaxBits = (MaxA > 9) ? MaxA : 9;
  localparam int unsigned BitW    = $clog2(MaxBits);

  typedef enum logic [2:0] {
    StIdle,
    StRegShift,
    StRegLatch,
    StGap,
    StSpiShift,
    StSpiRead,
    StDone
  } state_e;

  // Phase flags for a mode: {reg chain, spi write, 9-bit write, spi read}.
  function automatic logic [3:0] decode_mode(input logic [3:0] mode);
    logic [3:0] f;
    f = 4'b0000;
    case (mode)
      4'd0: f = 4'b1000;
      4'd1: f = 4'b1100;
      4'd2: f = 4'b1110;
      4'd4: f = 4'b0100;
      4'd5: f = 4'b0110;
`ifdef REGSPI_READ_EN
      4'd3: f = 4'b1001;
      4'd6: f = 4'b0001;
`else
      4'd3: f = 4'b1000;
`endif
      default: f = 4'b0000;
    endcase
    return f;
  endfunction

  state_e              r_state, w_state_d;
  logic [3:0]          r_mode, w_mode_d;
  logic [REG_BITS-1:0] r_reg_sr, w_reg_sr_d;
  logic [8:0]          r_spi_sr, w_spi_sr_d;  // byte plus the trailing 0 used by 9-bit writes
  logic [DivW-1:0]     r_div, w_div_d;
  logic                r_half, w_half_d;      // 0: SCLK low half, 1: SCLK high half
  logic [BitW-1:0]     r_bit, w_bit_d;
  logic                r_reg_sclk, r_reg_sdo, r_reg_latch, r_spi_sclk, r_spi_mosi, r_done;
  logic                r_oe_n;
  logic [3:0]          w_flags;
  logic                w_wrap, w_fall;
  logic [DivW-1:0]     w_tick_div;
  logic                w_tick_half;

  // In IDLE the flags come from the live mode so the first phase is chosen on the load cycle.
  assign w_flags     = decode_mode((r_state == StIdle) ? regspi_mode : r_mode);
  assign w_wrap      = (r_div == DivW'(CLK_DIV - 1));
  assign w_fall      = w_wrap & r_half;
  assign w_tick_div  = w_wrap ? '0 : r_div + DivW'(1);
  assign w_tick_half = w_wrap ? ~r_half : r_half;

  always_comb begin
    w_state_d  = r_state;
    w_mode_d   = r_mode;
    w_reg_sr_d = r_reg_sr;
    w_spi_sr_d = r_spi_sr;
    w_div_d    = r_div;
    w_half_d   = r_half;
    w_bit_d    = r_bit;
    case (r_state)
      StIdle: begin
        if (regspi_load && !r_done) begin
          w_mode_d   = regspi_mode;
          w_reg_sr_d = reg_word;
          w_spi_sr_d = {spi_word8, 1'b0};
          w_div_d    = '0;
          w_half_d   = 1'b0;
          w_bit_d    = '0;
          if (w_flags[3])      w_state_d = StRegShift;
          else if (w_flags[2]) w_state_d = StSpiShift;
          else if (w_flags[0]) w_state_d = StSpiRead;
          else                 w_state_d = StDone;
        end
      end
      StRegShift: begin
        w_div_d  = w_tick_div;
        w_half_d = w_tick_half;
        if (w_fall) begin
          w_bit_d    = r_bit + BitW'(1);
          w_reg_sr_d = {r_reg_sr[REG_BITS-2:0], 1'b0};
          if (r_bit == BitW'(REG_BITS - 1)) w_state_d = StRegLatch;
        end
      end
      StRegLatch: begin
        w_div_d = w_tick_div;
        if (w_wrap) w_state_d = (w_flags[2] || w_flags[0]) ? StGap : StDone;
      end
      StGap: begin
        w_div_d = w_tick_div;
        if (w_wrap) begin
          w_half_d  = 1'b0;
          w_bit_d   = '0;
          w_state_d = w_flags[2] ? StSpiShift : StSpiRead;
        end
      end
      StSpiShift: begin
        w_div_d  = w_tick_div;
        w_half_d = w_tick_half;
        if (w_fall) begin
          w_bit_d    = r_bit + BitW'(1);
          w_spi_sr_d = {r_spi_sr[7:0], 1'b0};
          if (r_bit == (w_flags[1] ? BitW'(8) : BitW'(7))) w_state_d = StDone;
        end
      end
      StSpiRead: begin
        w_div_d  = w_tick_div;
        w_half_d = w_tick_half;
        if (w_fall) begin
          w_bit_d = r_bit + BitW'(1);
          if (r_bit == BitW'(READ_BITS - 1)) w_state_d = StDone;
        end
      end
      StDone: begin
        if (!regspi_load) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Pins are registered from next-state values so each pin reflects the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_mode      <= '0;
      r_reg_sr    <= '0;
      r_spi_sr    <= '0;
      r_div       <= '0;
      r_half      <= 1'b0;
      r_bit       <= '0;
      r_reg_sclk  <= 1'b0;
      r_reg_sdo   <= 1'b0;
      r_reg_latch <= 1'b0;
      r_spi_sclk  <= 1'b0;
      r_spi_mosi  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_mode      <= w_mode_d;
      r_reg_sr    <= w_reg_sr_d;
      r_spi_sr    <= w_spi_sr_d;
      r_div       <= w_div_d;
      r_half      <= w_half_d;
      r_bit       <= w_bit_d;
      r_reg_sclk  <= (w_state_d == StRegShift) & w_half_d;
      r_reg_sdo   <= (w_state_d == StRegShift) & w_reg_sr_d[REG_BITS-1];
      r_reg_latch <= (w_state_d == StRegLatch);
      r_spi_sclk  <= ((w_state_d == StSpiShift) || (w_state_d == StSpiRead)) & w_half_d;
      r_spi_mosi  <= (w_state_d == StSpiShift) & w_spi_sr_d[8];
      r_done      <= (w_state_d == StDone);
    end
  end

  // Output-enable copy runs independently of the command FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_oe_n <= 1'b1;
    else     r_oe_n <= reg_en_n;
  end

  assign regspi_done = r_done;
  assign reg_sclk    = r_reg_sclk;
  assign reg_sdo     = r_reg_sdo;
  assign reg_latch   = r_reg_latch;
  assign reg_oe_n    = r_oe_n;
  assign spi_sclk    = r_spi_sclk;
  assign spi_mosi    = r_spi_mosi;

`ifdef REGSPI_READ_EN
  logic [READ_BITS-1:0] r_rd_sr, r_read_data;
  logic                 r_read_valid;

  // MISO is sampled in the cycle SCLK goes high (first cycle of the high half).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_sr      <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= 1'b0;
      if ((r_state == StSpiRead) && r_half && (r_div == '0)) begin
        r_rd_sr <= {r_rd_sr[READ_BITS-2:0], spi_miso};
      end
      if ((r_state == StSpiRead) && (w_state_d == StDone)) begin
        r_read_data  <= r_rd_sr;
        r_read_valid <= 1'b1;
      end
    end
  end

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
`else
  logic w_unused_miso;
  assign w_unused_miso = spi_miso;
  assign read_data     = '0;
  assign read_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_spi_engine.sv
`timescale 1ns/1ps
module tb_reg_spi_engine;

  localparam int unsigned CLK_DIV = 4;

  logic        clk;
  logic        rst;
  logic        regspi_load;
  logic [3:0]  regspi_mode;
  logic [23:0] reg_word;
  logic [7:0]  spi_word8;
  logic        reg_en_n;
  logic        regspi_done;
  logic        reg_sclk, reg_sdo, reg_latch, reg_oe_n;
  logic        spi_sclk, spi_mosi, spi_miso;
  logic [15:0] read_data;
  logic        read_valid;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] exp_rd = 16'h0;
  bit          reg_q[$];
  bit          spi_q[$];

  reg_spi_engine #(
    .CLK_DIV  (CLK_DIV),
    .REG_BITS (24),
    .READ_BITS(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .regspi_load(regspi_load),
    .regspi_mode(regspi_mode),
    .reg_word   (reg_word),
    .spi_word8  (spi_word8),
    .reg_en_n   (reg_en_n),
    .regspi_done(regspi_done),
    .reg_sclk   (reg_sclk),
    .reg_sdo    (reg_sdo),
    .reg_latch  (reg_latch),
    .reg_oe_n   (reg_oe_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .read_data  (read_data),
    .read_valid (read_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Done latency in CLK_DIV units for each mode (no-op is 0: done at cycle 1).
  function automatic int mode_k(input logic [3:0] m);
    case (m)
      4'd0: return 49;
      4'd1: return 66;
      4'd2: return 68;
`ifdef REGSPI_READ_EN
      4'd3: return 82;
      4'd6: return 32;
`else
      4'd3: return 49;
`endif
      4'd4: return 16;
      4'd5: return 18;
      default: return 0;
    endcase
  endfunction

  function automatic bit mode_rd(input logic [3:0] m);
`ifdef REGSPI_READ_EN
    return (m == 4'd3) || (m == 4'd6);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_cmd(input string name, input logic [3:0] mode, input logic [23:0] rw,
                         input logic [7:0] w8, input int hold, input bit early_drop,
                         input logic [15:0] miso_word);
    bit has_reg, has_wr, is9, has_rd, finished, p_rs, p_ss;
    int exp_done, done_cyc, drop_cyc, done_hi, lat_first, lat_last, rv_cnt, rv_cyc;
    int reg_rises, spi_rises, exp_reg_rises, exp_spi_rises, miso_idx;
    has_reg  = (mode <= 4'd3);
    has_wr   = (mode == 4'd1) || (mode == 4'd2) || (mode == 4'd4) || (mode == 4'd5);
    is9      = (mode == 4'd2) || (mode == 4'd5);
    has_rd   = mode_rd(mode);
    exp_done = 1 + mode_k(mode) * CLK_DIV;
    reg_q.delete();
    spi_q.delete();
    if (has_reg) for (int i = 23; i >= 0; i--) reg_q.push_back(rw[i]);
    if (has_wr) begin
      for (int i = 7; i >= 0; i--) spi_q.push_back(w8[i]);
      if (is9) spi_q.push_back(1'b0);
    end
    if (has_rd) for (int i = 0; i < 16; i++) spi_q.push_back(1'b0);
    exp_reg_rises = reg_q.size();
    exp_spi_rises = spi_q.size();
    finished = 0; p_rs = 0; p_ss = 0;
    done_cyc = -1; drop_cyc = -1; done_hi = 0; lat_first = -1; lat_last = -1;
    rv_cnt = 0; rv_cyc = -1; reg_rises = 0; spi_rises = 0;
    miso_idx = 15;
    spi_miso = miso_word[15];
    @(negedge clk);
    regspi_load = 1'b1;
    regspi_mode = mode;
    reg_word    = rw;
    spi_word8   = w8;
    for (int cyc = 1; cyc <= exp_done + 64 && !finished; cyc++) begin
      @(negedge clk);
      if (reg_sclk && !p_rs) begin
        reg_rises++;
        if (reg_q.size() > 0) chk({name, "_reg_sdo"}, reg_sdo, reg_q.pop_front());
      end
      if (spi_sclk && !p_ss) begin
        spi_rises++;
        if (spi_q.size() > 0) chk({name, "_spi_mosi"}, spi_mosi, spi_q.pop_front());
      end
      // Slave model: next MISO bit after each SCLK falling edge.
      if (p_ss && !spi_sclk && miso_idx > 0) begin
        miso_idx--;
        spi_miso = miso_word[miso_idx];
      end
      p_rs = reg_sclk;
      p_ss = spi_sclk;
      if (reg_latch) begin
        if (lat_first < 0) lat_first = cyc;
        lat_last = cyc;
      end
      if (read_valid) begin
        rv_cnt++;
        rv_cyc = cyc;
      end
      if (regspi_done) done_hi++;
      if (drop_cyc >= 0) begin
        chk({name, "_done_release"}, regspi_done, 1'b0);
        finished = 1;
      end else if (regspi_done) begin
        if (done_cyc < 0) done_cyc = cyc;
        if (!regspi_load || (cyc - done_cyc) >= hold) begin
          regspi_load = 1'b0;
          drop_cyc    = cyc;
        end
      end
      if (cyc == 1) begin
        regspi_mode = ~mode;
        reg_word    = ~rw;
        spi_word8   = ~w8;
        if (early_drop) regspi_load = 1'b0;
      end
    end
    regspi_load = 1'b0;
    chk({name, "_finished"}, finished, 1'b1);
    chk({name, "_done_cycle"}, done_cyc, exp_done);
    chk({name, "_done_width"}, done_hi, early_drop ? 1 : hold + 1);
    chk({name, "_reg_edges"}, reg_rises, exp_reg_rises);
    chk({name, "_spi_edges"}, spi_rises, exp_spi_rises);
    chk({name, "_latch_first"}, lat_first, has_reg ? 1 + 48 * CLK_DIV : -1);
    chk({name, "_latch_last"}, lat_last, has_reg ? 49 * CLK_DIV : -1);
    if (has_rd) begin
      exp_rd = miso_word;
      chk({name, "_rv_cycle"}, rv_cyc, exp_done);
    end
    chk({name, "_rv_count"}, rv_cnt, has_rd ? 1 : 0);
    chk({name, "_read_data"}, read_data, exp_rd);
  endtask

  initial begin
    rst         = 1'b1;
    regspi_load = 1'b0;
    regspi_mode = 4'd0;
    reg_word    = 24'h0;
    spi_word8   = 8'h0;
    reg_en_n    = 1'b0;
    spi_miso    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pins", {regspi_done, reg_sclk, reg_sdo, reg_latch, spi_sclk, spi_mosi,
                       read_valid, reg_oe_n}, 8'b0000_0001);
    chk("reset_rdata", read_data, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("oe_follow_low", reg_oe_n, 1'b0);
    reg_en_n = 1'b1;
    #1;
    chk("oe_latency", reg_oe_n, 1'b0);
    @(negedge clk);
    chk("oe_follow_high", reg_oe_n, 1'b1);

    run_cmd("reg",      4'd0, 24'hA5F00F, 8'h00, 0, 1'b0, 16'h0000);
    run_cmd("spi8",     4'd4, 24'h000000, 8'h3C, 3, 1'b0, 16'h0000);
    run_cmd("reg_read", 4'd3, 24'h3C0FF1, 8'h00, 0, 1'b0, 16'hBEEF);
    run_cmd("spi9",     4'd5, 24'h000000, 8'hFF, 0, 1'b1, 16'h0000);
    run_cmd("noop7",    4'd7, 24'hFFFFFF, 8'hFF, 0, 1'b0, 16'h0000);
    run_cmd("read",     4'd6, 24'h000000, 8'h00, 1, 1'b0, 16'h1234);
    run_cmd("reg_spi9", 4'd2, 24'h123456, 8'h81, 0, 1'b1, 16'h0000);
    run_cmd("reg_spi8", 4'd1, 24'h800001, 8'hA6, 2, 1'b0, 16'h0000);

    // Reset in the middle of REG_SHIFT while SCLK and SDO are high.
    reg_en_n = 1'b0;
    @(negedge clk);
    regspi_load = 1'b1;
    regspi_mode = 4'd0;
    reg_word    = 24'hFFFFFF;
    repeat (6) @(negedge clk);
    chk("pre_rst_sclk", reg_sclk, 1'b1);
    chk("pre_rst_sdo", reg_sdo, 1'b1);
    chk("pre_rst_oe", reg_oe_n, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_pins", {regspi_done, reg_sclk, reg_sdo, reg_latch, spi_sclk, spi_mosi,
                           read_valid, reg_oe_n}, 8'b0000_0001);
    chk("rst_async_rdata", read_data, 16'h0);
    exp_rd      = 16'h0;
    regspi_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd("post_rst", 4'd0, 24'h5A0FF0, 8'h00, 0, 1'b0, 16'h0000);
    run_cmd("noop15",   4'd15, 24'h0F0F0F, 8'h55, 2, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
